// File: rtl/draw_sequencer.sv
// Runs N drawing engines one after another through their start/done handshake
// and routes the running engine onto the single shared vga_adapter port.
module draw_sequencer #(
    parameter int N_CLIENTS      = 2,
    parameter int X_WIDTH        = 8,
    parameter int Y_WIDTH        = 7,
    parameter int COLOUR_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [N_CLIENTS-1:0]              enable_mask,
    output logic                              done,
    output logic                              busy,
    output logic                              error,
    output logic [3:0]                        cur_client,
    output logic [N_CLIENTS-1:0]              client_start,
    input  logic [N_CLIENTS-1:0]              client_done,
    input  logic [N_CLIENTS*X_WIDTH-1:0]      client_x,
    input  logic [N_CLIENTS*Y_WIDTH-1:0]      client_y,
    input  logic [N_CLIENTS*COLOUR_WIDTH-1:0] client_colour,
    input  logic [N_CLIENTS-1:0]              client_plot,
    output logic [X_WIDTH-1:0]                vga_x,
    output logic [Y_WIDTH-1:0]                vga_y,
    output logic [COLOUR_WIDTH-1:0]           vga_colour,
    output logic                              vga_plot
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   index;
    logic [N_CLIENTS-1:0] mask;
    logic [WD_W-1:0]    wd_cnt;

    logic               first_found;
    logic [IDX_W-1:0]   first_idx;
    logic               next_found;
    logic [IDX_W-1:0]   next_idx;
    logic               run_done;
    logic               wd_expired;

    // Scanning from the top down leaves the lowest qualifying index in place.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path holds a stale value and no latch is inferred.
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        run_done    = 1'b0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (enable_mask[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (mask[i] && (i > int'(index))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
            if (index == IDX_W'(i)) begin
                run_done = client_done[i];
            end
        end
    end

    assign wd_expired = WD_ON && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state  <= IDLE;
            index  <= '0;
            mask   <= '0;
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask   <= enable_mask;
                        error  <= 1'b0;
                        wd_cnt <= '0;
                        if (first_found) begin
                            state <= RUN;
                            index <= first_idx;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (run_done) begin
                        state <= GAP;
                    end else if (wd_expired) begin
                        error <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    wd_cnt <= '0;
                    if (next_found) begin
                        state <= RUN;
                        index <= next_idx;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Engine outputs reach the port only while that engine is running, with no added latency.
    always_comb begin
        client_start = '0;
        vga_x        = '0;
        vga_y        = '0;
        vga_colour   = '0;
        vga_plot     = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (index == IDX_W'(i)) begin
                    client_start[i] = 1'b1;
                    vga_x           = client_x[i*X_WIDTH +: X_WIDTH];
                    vga_y           = client_y[i*Y_WIDTH +: Y_WIDTH];
                    vga_colour      = client_colour[i*COLOUR_WIDTH +: COLOUR_WIDTH];
                    vga_plot        = client_plot[i];
                end
            end
        end
    end

    assign done       = (state == DONE);
    assign busy       = (state == RUN) || (state == GAP);
    assign cur_client = (state == RUN) ? 4'(index) : 4'd0;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: three engines, 8-cycle watchdog, simple
// behavioural engines that raise done after a programmed number of run cycles.
module tb_draw_sequencer;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [N-1:0]    enable_mask;
    logic            done;
    logic            busy;
    logic            error;
    logic [3:0]      cur_client;
    logic [N-1:0]    client_start;
    logic [N-1:0]    client_done;
    logic [N*XW-1:0] client_x;
    logic [N*YW-1:0] client_y;
    logic [N*CW-1:0] client_colour;
    logic [N-1:0]    client_plot;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot;

    int n_cmp = 0;
    int n_bad = 0;

    // Engine model: done rises on run cycle eng_len (0 = engine hangs).
    int           eng_len [N];
    logic [7:0]   eng_cnt [N];
    logic [N-1:0] spur;

    draw_sequencer #(
        .N_CLIENTS(N), .X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .enable_mask(enable_mask),
        .done(done), .busy(busy), .error(error), .cur_client(cur_client),
        .client_start(client_start), .client_done(client_done),
        .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
        .client_plot(client_plot), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < N; i++) eng_cnt[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) eng_cnt[i] <= client_start[i] ? eng_cnt[i] + 8'd1 : 8'd0;
    end

    always_comb begin
        client_done = spur;
        for (int i = 0; i < N; i++) begin
            if (client_start[i] && eng_len[i] != 0 && int'(eng_cnt[i]) == eng_len[i] - 1)
                client_done[i] = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_phase(input logic [N-1:0] cs, input int cycles, input logic [3:0] cur);
        for (int k = 0; k < cycles; k++) begin
            check("run_client_start", 32'(client_start), 32'(cs));
            check("run_cur_client", 32'(cur_client), 32'(cur));
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            tick();
        end
    endtask

    task automatic gap_phase();
        check("gap_client_start", 32'(client_start), 32'd0);
        check("gap_vga_plot", 32'(vga_plot), 32'd0);
        check("gap_vga_x", 32'(vga_x), 32'd0);
        check("gap_cur_client", 32'(cur_client), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        enable_mask   = '0;
        spur          = '0;
        eng_len       = '{5, 3, 4};
        client_x      = {8'h33, 8'h22, 8'h11};
        client_y      = {7'h23, 7'h22, 7'h21};
        client_colour = {3'd3, 3'd2, 3'd1};
        client_plot   = 3'b111;
        tick();
        tick();

        // Reset state
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cur_client", 32'(cur_client), 32'd0);
        check("rst_client_start", 32'(client_start), 32'd0);
        check("rst_vga_plot", 32'(vga_plot), 32'd0);
        check("rst_vga_x", 32'(vga_x), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Two engines, lengths 5 and 3
        enable_mask = 3'b011;
        start       = 1'b1;
        tick();
        run_phase(3'b001, 5, 4'd0);
        gap_phase();
        run_phase(3'b010, 3, 4'd1);
        gap_phase();
        for (int k = 0; k < 3; k++) begin
            check("t1_done", 32'(done), 32'd1);
            check("t1_busy", 32'(busy), 32'd0);
            check("t1_error", 32'(error), 32'd0);
            check("t1_client_start", 32'(client_start), 32'd0);
            tick();
        end
        start = 1'b0;
        tick();
        check("t1_idle_done", 32'(done), 32'd0);

        // Mask 101: engine 1 skipped, vga follows engines 0 and 2 only; mask change ignored
        eng_len     = '{2, 3, 2};
        enable_mask = 3'b101;
        start       = 1'b1;
        tick();
        enable_mask = 3'b010;
        check("t2_vga_x0", 32'(vga_x), 32'h11);
        check("t2_vga_y0", 32'(vga_y), 32'h21);
        check("t2_vga_col0", 32'(vga_colour), 32'd1);
        check("t2_vga_plot0", 32'(vga_plot), 32'd1);
        client_x[7:0] = 8'h5a;
        #1;
        check("t2_vga_x0_live", 32'(vga_x), 32'h5a);
        client_x[7:0] = 8'h11;
        run_phase(3'b001, 2, 4'd0);
        gap_phase();
        check("t2_vga_x2", 32'(vga_x), 32'h33);
        check("t2_vga_y2", 32'(vga_y), 32'h23);
        check("t2_vga_col2", 32'(vga_colour), 32'd3);
        run_phase(3'b100, 2, 4'd2);
        gap_phase();
        check("t2_done", 32'(done), 32'd1);
        check("t2_vga_plot_done", 32'(vga_plot), 32'd0);
        start = 1'b0;
        tick();

        // Empty mask: straight to DONE, held without restart
        enable_mask = 3'b000;
        start       = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("t3_done", 32'(done), 32'd1);
            check("t3_busy", 32'(busy), 32'd0);
            check("t3_client_start", 32'(client_start), 32'd0);
            tick();
        end
        start = 1'b0;
        tick();
        check("t3_idle_done", 32'(done), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);

        // Watchdog: engine 0 hangs, aborted after 8 cycles, engine 1 runs normally
        eng_len     = '{0, 3, 4};
        enable_mask = 3'b011;
        start       = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("t4_error_run", 32'(error), 32'd0);
            run_phase(3'b001, 1, 4'd0);
        end
        check("t4_error_gap", 32'(error), 32'd1);
        gap_phase();
        run_phase(3'b010, 3, 4'd1);
        gap_phase();
        check("t4_done", 32'(done), 32'd1);
        check("t4_error_done", 32'(error), 32'd1);
        start = 1'b0;
        tick();
        check("t4_error_idle", 32'(error), 32'd1);

        // Reset during engine 1, then restart from engine 0
        eng_len = '{2, 5, 4};
        start   = 1'b1;
        tick();
        check("t5_error_cleared", 32'(error), 32'd0);
        run_phase(3'b001, 2, 4'd0);
        gap_phase();
        run_phase(3'b010, 1, 4'd1);
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        check("t5_rst_client_start", 32'(client_start), 32'd0);
        check("t5_rst_vga_plot", 32'(vga_plot), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_error", 32'(error), 32'd0);
        check("t5_rst_cur_client", 32'(cur_client), 32'd0);
        rst_n = 1'b1;
        tick();

        // Restart, with a spurious done from engine 1 while engine 0 runs
        eng_len = '{4, 2, 4};
        start   = 1'b1;
        tick();
        spur = 3'b010;
        run_phase(3'b001, 4, 4'd0);
        spur = 3'b000;
        gap_phase();
        run_phase(3'b010, 2, 4'd1);
        gap_phase();
        check("t6_done", 32'(done), 32'd1);
        check("t6_error", 32'(error), 32'd0);
        start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Parametrised sequencer and VGA-port arbiter for N drawing engines (fillscreen, circle, reuleaux, and later engines) that share one vga_adapter port. On a single start it runs each enabled engine in index order through its start/done handshake. It muxes the running engine's vga_x/vga_y/vga_colour/vga_plot onto the shared port and reports overall completion. An optional watchdog aborts a hung engine and flags the error.

Parameters:
N_CLIENTS, 2, number of drawing engines (1..16)
X_WIDTH, 8, width of x coordinate
Y_WIDTH, 7, width of y coordinate
COLOUR_WIDTH, 3, width of colour
TIMEOUT_CYCLES, 0, watchdog limit in cycles per engine run; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  begin sequence; level, held high until done is seen
enable_mask  in  N_CLIENTS  engines to run this sequence; sampled on accept
done  out  1  sequence complete; held while start stays high
busy  out  1  high from accept until done is asserted
error  out  1  sticky watchdog abort flag for the current/last sequence
cur_client  out  4  index of the running engine; 0 when none is running
client_start  out  N_CLIENTS  per-engine start; at most one bit high
client_done  in  N_CLIENTS  per-engine done
client_x  in  N_CLIENTS*X_WIDTH  packed engine x; engine i at [i*X_WIDTH +: X_WIDTH]
client_y  in  N_CLIENTS*Y_WIDTH  packed engine y
client_colour  in  N_CLIENTS*COLOUR_WIDTH  packed engine colour
client_plot  in  N_CLIENTS  engine plot strobes
vga_x  out  X_WIDTH  to vga_adapter
vga_y  out  Y_WIDTH
vga_colour  out  COLOUR_WIDTH
vga_plot  out  1

Behaviour:
- States: IDLE, RUN, GAP, DONE. All outputs are derived from registered state and registered index.
- Reset, at a clk edge with rst_n=0, from any state: state=IDLE, index=0, latched mask=0, watchdog counter=0, error=0. Outputs: done=0, busy=0, cur_client=0, client_start=0, vga_* all 0. A reset mid-sequence drops client_start immediately and does not wait for the engine. Engines share rst_n.
- IDLE, start=1 at an edge: latch enable_mask and clear error. If the mask is nonzero, go to RUN with index = lowest set bit. If the mask is all zero, go to DONE.
- RUN: client_start[index]=1; busy=1; cur_client=index. vga_x/y/colour/plot are driven combinationally from engine index, with no added latency. Engine i's outputs pass through only while i is running.
- RUN, client_done[index]=1: go to GAP. client_done from non-running engines is ignored.
- Watchdog: the counter clears on RUN entry and increments every RUN cycle. If TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 without done, set error=1 and go to GAP; this is an abort.
- GAP: exactly one cycle. All client_start=0 and vga_plot=0, so the finished engine sees start low and re-arms. Next state is RUN with index = lowest latched-mask bit above the current index, or DONE if there is none.
- DONE: done=1, busy=0, vga_plot=0. The sequence returns to IDLE on the first edge with start=0. A start held high never re-triggers a sequence.
- Outside RUN: vga_x/y/colour=0 and vga_plot=0.
- Changes to enable_mask during a sequence have no effect.
- Latency: start edge to first client_start is 1 cycle. Engine done to next client_start is 2 cycles.
- error holds through DONE and IDLE; it clears on the next accept or on reset.

Test Plan:
- N=2, mask=2'b11, engine 0 done after 5 RUN cycles, engine 1 after 3 -> client_start pattern 01 x5, 00 x1, 10 x3, 00; done=1 on the following cycle; cur_client goes 0 then 1; error=0.
- mask=3'b101, N=3 -> engine 1 never started; sequence runs 0, GAP, 2; vga_* follows engine 0 then engine 2 only, and vga_plot=0 in GAP.
- mask=0, start=1 -> done=1 one cycle after the start edge, busy never high, no client_start. Hold start high 10 cycles -> done stays 1 and no restart. Drop start -> IDLE next edge.
- TIMEOUT_CYCLES=8, engine 0 never asserts done -> client_start[0] high exactly 8 cycles, error=1, engine 1 then runs normally, and error is still 1 in DONE.
- rst_n=0 during engine 1 RUN -> next edge gives client_start=0, vga_plot=0, busy=0, done=0, error=0. A new start after reset runs from engine 0.
- Spurious client_done[1]=1 while engine 0 is running -> ignored; sequencing is unchanged.
